// File: rtl/hand_card_stack.sv
// hand_card_stack: LIFO card stack, newest card in slot 0. Every slot is exposed in
// parallel. Also tracks occupancy, a running total of card values, full/empty
// flags and a sticky error flag for rejected pushes or pops.
module hand_card_stack #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 11,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned SUM_W  = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    clear_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DEPTH*DATA_W-1:0] slots_o,
  output logic [CNT_W-1:0]        count_o,
  output logic [SUM_W-1:0]        sum_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    err_o
);

  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              err_q, err_d;
  logic              full, empty;
  logic [SUM_W-1:0]  data_ext, top_ext;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign data_ext = SUM_W'(data_i);
  assign top_ext  = SUM_W'(slot_q[0]);

  // Next-state decode: clear beats push/pop; push+pop on a non-empty hand replaces
  // the newest card, on an empty hand it degrades to a plain push.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
    cnt_d = cnt_q;
    sum_d = sum_q;
    err_d = err_q;
    if (clear_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_d[k] = '0;
      cnt_d = '0;
      sum_d = '0;
      err_d = 1'b0;
    end else if (push_i && (!pop_i || empty)) begin
      if (full) begin
        // Card is dropped rather than shifted out of the last slot.
        err_d = 1'b1;
      end else begin
        for (int unsigned k = 1; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
        slot_d[0] = data_i;
        cnt_d     = cnt_q + CNT_W'(1);
        sum_d     = sum_q + data_ext;
      end
    end else if (push_i && pop_i) begin
      slot_d[0] = data_i;
      sum_d     = sum_q - top_ext + data_ext;
    end else if (pop_i) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned k = 0; k < DEPTH - 1; k++) slot_d[k] = slot_q[k+1];
        slot_d[DEPTH-1] = '0;
        cnt_d           = cnt_q - CNT_W'(1);
        sum_d           = sum_q - top_ext;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slots
    assign slots_o[g*DATA_W +: DATA_W] = slot_q[g];
  end

  assign count_o = cnt_q;
  assign sum_o   = sum_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign err_o   = err_q;

endmodule

// File: doc/hand_card_stack.md
Name: hand_card_stack

Overview:
Parametrised successor of the 11-slot card buffer. Stores dealt cards newest-first in a LIFO shift stack and exposes every slot in parallel to the scoring and display logic. Adds features the previous buffer lacked: removal of the newest card (undo), a per-hand clear, occupancy count, full/empty flags, a sticky error flag, and a registered running total of the stored card values.

Parameters:
DATA_W, 8, width of one card entry in bits
DEPTH, 11, number of card slots; must be 2 or more
CNT_W, 4, width of the occupancy count; must satisfy 2^CNT_W > DEPTH
SUM_W, 12, width of the running total; must satisfy 2^SUM_W > DEPTH*(2^DATA_W-1)

Ports:
clk_i  in  1  single clock; all logic on the rising edge
rst_i  in  1  synchronous, active-low reset
push_i  in  1  store data_i as the newest card
pop_i  in  1  remove the newest card
clear_i  in  1  empty the hand (synchronous)
data_i  in  DATA_W  card value sampled when push_i=1
slots_o  out  DEPTH*DATA_W  flat slot bus; bits [DATA_W-1:0] = slot 0 (newest); slot k at [k*DATA_W +: DATA_W]
count_o  out  CNT_W  number of valid slots
sum_o  out  SUM_W  sum of all valid slot values, zero-extended
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
err_o  out  1  sticky flag: set by a rejected push or pop

Behaviour:
- All outputs are registered or derived purely from registers. Every update is visible on the cycle after the sampling edge.
- Reset: when rst_i=0 at a rising edge:
  - all slots, count_o, sum_o and err_o go to 0;
  - empty_o=1, full_o=0.
  - Reset is sampled only on the clock edge and overrides every other input.
- Priority per edge: reset > clear_i > push/pop decode.
- clear_i=1: all slots, count_o and sum_o go to 0; err_o is also cleared; push_i and pop_i are ignored that cycle.
- Decode with clear_i=0:
  - push only, not full:
    - slot[k] <= slot[k-1] for k=1..DEPTH-1, slot[0] <= data_i;
    - count +1; sum += data_i.
  - push only, full: no state change; err_o <= 1. The card is dropped, never shifted out of slot DEPTH-1.
  - pop only, not empty:
    - slot[k] <= slot[k+1] for k=0..DEPTH-2, slot[DEPTH-1] <= 0;
    - count -1; sum -= old slot[0].
  - pop only, empty: no state change; err_o <= 1.
  - push and pop, not empty (replace newest card):
    - slot[0] <= data_i, other slots unchanged;
    - count unchanged; sum <= sum - old slot[0] + data_i.
    - Legal even when full.
  - push and pop, empty: behaves as push only, with no error.
  - neither: hold.
- Invariants:
  - slots at index >= count_o always read 0;
  - sum_o always equals the sum of the valid slots;
  - count_o never exceeds DEPTH and never wraps.
- Sum arithmetic is unsigned, SUM_W wide, with data_i zero-extended. The parameter constraints make overflow impossible.
- err_o stays at 1 until reset or clear_i.
- Width rule: data_i is stored unmodified; no card-value validation is done in this block.

Test Plan:
1. Reset, then push 3, 7, 10 on consecutive cycles -> count_o=3, slot0=10, slot1=7, slot2=3, slots 3..10=0, sum_o=20, empty_o=0, err_o=0.
2. Push 11 cards of value 1, then push 9 -> full_o=1, count_o=11, sum_o=11, the 9 is absent, err_o=1; then clear_i -> count_o=0, sum_o=0, empty_o=1, err_o=0.
3. From hand {5,2} (newest 5), pop -> slot0=2, slot1=0, count_o=1, sum_o=2; pop twice more -> count_o=0 and err_o=1 after the second pop.
4. From a full hand, push 4 and pop in the same cycle with slot0=8 -> slot0=4, count_o=11, sum_o drops by 4, err_o=0; same push+pop on an empty hand -> count_o=1, slot0=4.
5. Push 6, then assert clear_i together with push_i=1 (data 9) -> hand empty, 9 not stored; rst_i=0 mid-sequence with push_i=1 -> all outputs zero next cycle, empty_o=1.
6. Regression with DEPTH=4, DATA_W=4, CNT_W=3, SUM_W=6: push 15 four times -> sum_o=60, full_o=1; a fifth push sets err_o and leaves the state unchanged.
